// File: rtl/result_serializer_pkg.sv
// Shared constants and state encoding for the result serializer.
package result_serializer_pkg;

  // One compressor word: columns dst0..dst53 of a 27x27 cascade.
  localparam int unsigned WIDTH_DEFAULT = 54;

  // Bits needed to count columns 0..w-1. A minimum of one bit keeps
  // degenerate widths legal.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/result_bit_counter.sv
// Column counter for the serializer. Clear wins over increment. The
// terminal flag marks the last column of a word.
module result_bit_counter
  import result_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CW    = cnt_width(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count. The increment is never requested at terminal count,
  // because the owner clears or leaves SHIFT there, so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/result_serializer.sv
// Parallel-to-serial converter for compressor results. It streams the
// result LSB first with a valid/ready handshake and a last-bit marker.
// It supports zero-gap back-to-back words.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             last_col;

  result_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .tc_o  (last_col)
  );

  // Next-state and datapath control. Load is honoured only in IDLE, or
  // when it arrives together with the acceptance of the last column.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          sreg_d  = din;
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (dout_ready) begin
          if (last_col) begin
            cnt_clr = 1'b1;
            if (load) begin
              sreg_d = din;
            end else begin
              sreg_d  = '0;
              state_d = IDLE;
            end
          end else begin
            sreg_d  = sreg_q >> 1;
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and shift register. Reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

  assign dout_valid = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT);
  assign dout       = (state_q == SHIFT) & sreg_q[0];
  assign dout_last  = (state_q == SHIFT) & last_col;

endmodule

// File: tb/tb_result_serializer.sv
// Randomized self-checking bench for result_serializer. Each expected
// stream is derived directly from the loaded words: bit i of a word is
// column i, and the columns are sent in order.
module tb_result_serializer;
  localparam int W = 54;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic         dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         dout_last;
  logic         busy;

  int total = 0;
  int bad   = 0;

  result_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    #3;
    total++;
    if ({dout, dout_valid, dout_last, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0000", {dout, dout_valid, dout_last, busy});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset valid=%b busy=%b want 0 0", dout_valid, busy);
    end
    dout_ready = 1'b1;
    tick();
    total++;
    if (dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL ready_in_idle valid=%b want=0", dout_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [W-1:0] w;
    w = 54'h00000000000001;
    dout_ready = 1'b1;
    load = 1'b1;
    din  = w;
    total++;
    if (dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_pre_valid got=%b want=0", dout_valid);
    end
    tick();
    load = 1'b0;
    for (int i = 0; i < W; i++) begin
      total++;
      if (dout_valid !== 1'b1 || busy !== 1'b1 || dout !== w[i] || dout_last !== (i == W-1)) begin
        bad++;
        $display("FAIL basic_bit%0d valid=%b busy=%b dout=%b last=%b want 1 1 %b %b",
                 i, dout_valid, busy, dout, dout_last, w[i], (i == W-1));
      end
      tick();
    end
    total++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_end valid=%b busy=%b want 0 0", dout_valid, busy);
    end
    $display("test_basic word=%h done", w);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w;
    int ones, acc, guard;
    logic pd, pl;
    w = 54'h3FFFFFFFFFFFFF;
    ones = 0;
    acc = 0;
    guard = 0;
    load = 1'b1;
    din  = w;
    dout_ready = 1'b0;
    tick();
    load = 1'b0;
    din  = '0;
    while (acc < W && guard < 1000) begin
      dout_ready = 1'($urandom_range(0, 1));
      pd = dout;
      pl = dout_last;
      total++;
      if (dout_valid !== 1'b1 || dout_last !== (acc == W-1)) begin
        bad++;
        $display("FAIL bp_state acc=%0d valid=%b last=%b want 1 %b",
                 acc, dout_valid, dout_last, (acc == W-1));
      end
      if (dout_ready) begin
        if (dout === 1'b1) ones++;
        acc++;
        tick();
      end else begin
        tick();
        total++;
        if (dout_valid !== 1'b1 || dout !== pd || dout_last !== pl) begin
          bad++;
          $display("FAIL bp_stall acc=%0d valid=%b dout=%b last=%b want 1 %b %b",
                   acc, dout_valid, dout, dout_last, pd, pl);
        end
      end
      guard++;
    end
    total++;
    if (ones != W || acc != W || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_count ones=%0d acc=%0d valid=%b want %0d %0d 0", ones, acc, dout_valid, W, W);
    end
    dout_ready = 1'b1;
    $display("test_backpressure ones=%0d cycles=%0d done", ones, guard);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic [2*W-1:0] stream;
    a = 54'h15555555555555;
    b = 54'h0000000000FFFF;
    stream = {b, a};
    dout_ready = 1'b1;
    load = 1'b1;
    din  = a;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2*W; i++) begin
      total++;
      if (dout_valid !== 1'b1 || dout !== stream[i] || dout_last !== ((i % W) == W-1)) begin
        bad++;
        $display("FAIL b2b_xfer%0d valid=%b dout=%b last=%b want 1 %b %b",
                 i, dout_valid, dout, dout_last, stream[i], ((i % W) == W-1));
      end
      if (i == W-1) begin
        load = 1'b1;
        din  = b;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    total++;
    if (dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end valid=%b want=0", dout_valid);
    end
    $display("test_back_to_back a=%h b=%h done", a, b);
  endtask

  task automatic test_ignored_load();
    logic [W-1:0] w, other;
    w = rnd_word();
    other = ~w;
    dout_ready = 1'b1;
    load = 1'b1;
    din  = w;
    tick();
    load = 1'b0;
    for (int i = 0; i < W; i++) begin
      total++;
      if (dout_valid !== 1'b1 || dout !== w[i]) begin
        bad++;
        $display("FAIL ign_bit%0d valid=%b dout=%b want 1 %b", i, dout_valid, dout, w[i]);
      end
      load = (i >= 20 && i <= 22);
      din  = other;
      dout_ready = (i != 21);
      if (i == 21) begin
        tick();
        total++;
        if (dout !== w[i]) begin
          bad++;
          $display("FAIL ign_stall dout=%b want=%b", dout, w[i]);
        end
        dout_ready = 1'b1;
      end
      tick();
    end
    load = 1'b0;
    tick();
    total++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ign_end valid=%b busy=%b want 0 0", dout_valid, busy);
    end
    $display("test_ignored_load word=%h done", w);
  endtask

  task automatic test_reset_midword();
    logic [W-1:0] w;
    w = 54'h2AAAAAAAAAAAAA;
    dout_ready = 1'b1;
    load = 1'b1;
    din  = w;
    tick();
    load = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({dout, dout_valid, dout_last, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL midreset_async got=%b want=0000", {dout, dout_valid, dout_last, busy});
    end
    tick();
    load = 1'b1;
    din  = w;
    #1;
    rst = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < W; i++) begin
      total++;
      if (dout_valid !== 1'b1 || dout !== w[i] || dout_last !== (i == W-1)) begin
        bad++;
        $display("FAIL midreset_bit%0d valid=%b dout=%b last=%b want 1 %b %b",
                 i, dout_valid, dout, dout_last, w[i], (i == W-1));
      end
      tick();
    end
    total++;
    if (dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_end valid=%b want=0", dout_valid);
    end
    $display("test_reset_midword done");
  endtask

  task automatic test_end_to_end();
    localparam int N = 1000;
    logic [W-1:0] prod [N];
    logic [W-1:0] acc;
    logic [26:0]  a, b;
    int widx, bitn, guard;
    for (int k = 0; k < N; k++) begin
      a = 27'($urandom);
      b = 27'($urandom);
      prod[k] = W'(a) * W'(b);
    end
    dout_ready = 1'b1;
    load = 1'b1;
    din  = prod[0];
    tick();
    load = 1'b0;
    widx = 0;
    bitn = 0;
    guard = 0;
    acc = '0;
    while (widx < N && guard < 60000) begin
      if (dout_valid === 1'b1) begin
        acc[bitn] = dout;
        if (dout_last !== (bitn == W-1)) begin
          total++;
          bad++;
          $display("FAIL e2e_last word=%0d bit=%0d last=%b", widx, bitn, dout_last);
        end
        if (bitn == W-1) begin
          total++;
          if (acc !== prod[widx]) begin
            bad++;
            $display("FAIL e2e_word%0d got=%h want=%h", widx, acc, prod[widx]);
          end
          widx++;
          bitn = 0;
          load = (widx < N);
          if (widx < N) din = prod[widx];
        end else begin
          bitn++;
          load = 1'b0;
        end
      end else begin
        load = 1'b0;
      end
      tick();
      guard++;
    end
    load = 1'b0;
    total++;
    if (widx != N || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL e2e_done words=%0d valid=%b want %0d 0", widx, dout_valid, N);
    end
    $display("test_end_to_end words=%0d cycles=%0d done", widx, guard);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_ignored_load();
    test_reset_midword();
    test_end_to_end();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 Parameter WIDTH, default 54, number of compressor output columns captured per word (dst0..dst53 of a 27x27 cascade).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 load  input  1  capture strobe; samples din when accepted.
REQ-005 din  input  WIDTH  parallel compressor result; bit i = column dst_i.
REQ-006 dout  output  1  serial result bit, column 0 first (LSB first).
REQ-007 dout_valid  output  1  dout holds a valid bit.
REQ-008 dout_ready  input  1  downstream accepts dout this cycle when high together with dout_valid.
REQ-009 dout_last  output  1  high with the column WIDTH-1 bit only.
REQ-010 busy  output  1  word in flight; load is ignored except at REQ-017.

Function
REQ-011 SHALL implement two states, IDLE and SHIFT; IDLE is the reset state.
REQ-012 IDLE: load=1 SHALL capture din into a WIDTH-bit shift register, clear bit counter to 0, enter SHIFT on the same edge.
REQ-013 Latency: dout_valid SHALL rise exactly one cycle after the cycle load is accepted; dout then equals din[0].
REQ-014 SHIFT: dout_valid=1, busy=1, dout = shift register bit 0 continuously.
REQ-015 On dout_valid & dout_ready the register SHALL shift right by one (zero filled) and counter increment; without ready, dout, dout_last, counter SHALL hold unchanged (no bit dropped, no bit duplicated).
REQ-016 dout_last SHALL equal (counter == WIDTH-1) while in SHIFT; accepting the last bit SHALL return to IDLE.
REQ-017 Back-to-back: load=1 in the same cycle the last bit is accepted SHALL capture the new din and remain in SHIFT with counter 0, giving zero idle cycles between words.
REQ-018 load in SHIFT outside REQ-017 SHALL be ignored; captured word and counter unchanged.
REQ-019 Counter width SHALL be ceil(log2(WIDTH)) bits; counter never exceeds WIDTH-1 and never wraps within a word.
REQ-020 IDLE outputs: dout_valid=0, dout_last=0, busy=0, dout=0.
REQ-021 dout_ready while dout_valid=0 SHALL have no effect.
REQ-022 Exactly WIDTH accepted transfers per captured word, in column order 0..WIDTH-1.

Reset
REQ-023 rst=1 SHALL immediately, without clock, force IDLE, shift register 0, counter 0, dout=0, dout_valid=0, dout_last=0, busy=0.
REQ-024 Reset mid-word SHALL discard the remaining bits; no partial word resumes after release.
REQ-025 First load SHALL be accepted on the first rising edge with rst low.

Structure
REQ-026 Shared package SHALL hold WIDTH default (54), counter-width constant, and the state enumeration {IDLE, SHIFT}.
REQ-027 One sub-module, result_bit_counter (load-clear, enable-increment, terminal-count flag at WIDTH-1), SHALL be instantiated; the datapath shift register stays in result_serializer.

Verification
REQ-028 Reset mid-word: load din=54'h2AAAAAAAAAAAAA, accept 10 bits, assert rst -> outputs 0 immediately, next load restarts at bit 0.
REQ-029 Basic: load din=54'h00000000000001, ready held 1 -> dout_valid rises 1 cycle later; dout=1 first, then 53 zeros; dout_last only on transfer 54; busy drops after it.
REQ-030 Backpressure: load din=54'h3FFFFFFFFFFFFF, ready toggled pseudo-random -> exactly 54 accepted ones, dout stable on every stalled cycle.
REQ-031 Back-to-back: word A=54'h15555555555555 then load B=54'h0000000000FFFF in last-accept cycle -> 108 contiguous valid transfers, A then B, no gap.
REQ-032 Ignored load: load new din at bit 20 of a word -> current word output unchanged; new din never appears.
REQ-033 End-to-end: random 27x27 operands through shift_register/compressor, serialize dst0..dst53 -> reassembled word matches reference sum of dst columns for 1000 vectors.
